fencei_mc_flush_resp: RTL and testbench
=======================================

# fencei_mc_flush_resp

Multi-channel FENCE.I flush responder: serves the flush_req/flush_ack handshake for NUM_CH independent requesters through one shared flush engine. Requests are arbitrated round-robin, and each is acknowledged after a fixed or pseudo-random latency. Protocol violations are flagged and completed flushes are counted. The block sits in the testbench as the synthesizable responder behind the FENCEI agent's slave side, standing in for the instruction-cache flush logic.

## Interface
- NUM_CH, default 2: number of requester channels, at least 1.
- LAT_W, default 8: width of the latency configuration and the latency counter.
- CH_W, default $clog2(NUM_CH) with a minimum of 1: width of the channel index.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- flush_req  input  NUM_CH  per-channel flush request, level, held until acknowledged.
- flush_ack  output  NUM_CH  per-channel acknowledge, one-cycle pulse, registered.
- cfg_min_lat  input  LAT_W  fixed latency, or the lower bound when random.
- cfg_max_lat  input  LAT_W  upper bound for random latency.
- cfg_rand_en  input  1  1 selects pseudo-random latency.
- busy  output  1  high in every state except IDLE.
- active_ch  output  CH_W  channel currently granted; holds its last value while IDLE.
- proto_err  output  NUM_CH  one-cycle pulse when a granted request drops before its ack.
- flush_cnt  output  16  count of completed flushes, saturating.

## Operation
- Reset values: flush_ack=0, proto_err=0, busy=0, active_ch=0, flush_cnt=0, state=IDLE, latency counter=0, round-robin pointer=NUM_CH-1, LFSR=16'hACE1.
- FSM states and transitions:
  - IDLE: if any flush_req bit is set, grant the first set channel searching from pointer+1 with wrap. Load the counter with L, set active_ch and the pointer to the granted channel. Go to ACK if L==0, otherwise WAIT.
  - WAIT: decrement the counter each cycle. On reaching 0, go to ACK. If flush_req[active_ch]==0, abort: pulse proto_err[active_ch], no ack, go to RECOVER.
  - ACK: flush_ack[active_ch]=1 for exactly this cycle; flush_cnt increments; go to RECOVER.
  - RECOVER: one cycle with all requests ignored, so the just-acked requester can drop its request; then go to IDLE.
- Latency L:
  - cfg_rand_en=0: L=cfg_min_lat.
  - cfg_rand_en=1: L=min(cfg_min_lat + lfsr[LAT_W-1:0], cfg_max_lat), computed in LAT_W+1 bits.
  - If cfg_max_lat<cfg_min_lat, L=cfg_min_lat.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, steps every cycle out of reset. When LAT_W>16, lfsr bits are zero-extended.
- L is captured at grant; cfg changes during WAIT do not affect the flush in progress.
- flush_cnt saturates at 16'hFFFF and never wraps.
- flush_ack is never asserted on a channel whose request is low at the ACK edge.
- Only one flush_ack bit is ever high at a time.
- Reset asserted mid-operation clears all outputs immediately (asynchronously); no pending ack survives reset.
- NUM_CH=1: the pointer is constant and arbitration degenerates to a direct grant.

## Timing
- Request sampled high at the IDLE edge T → flush_ack high during cycle T+L+1 (L=0 gives ack one cycle after grant).
- Back-to-back requests from the same channel: minimum spacing from one ack to the next ack is L+3 cycles (RECOVER, IDLE grant, L wait cycles, ACK).
- proto_err is asserted in the cycle following the edge at which the drop was sampled.
- busy rises the cycle after grant and falls the cycle after RECOVER.
- Simultaneous requests: exactly one grant per IDLE visit; the others stay pending and are not lost.

## Test plan
- Single channel, cfg_min_lat=3, rand off, req held → one ack pulse 4 cycles after grant; flush_cnt=1; busy high 5 cycles.
- NUM_CH=4, all requests asserted together, latency 0, each requester drops its req after its ack → acks in order ch0,ch1,ch2,ch3, one every 3 cycles; flush_cnt=4.
- cfg_min_lat=2, cfg_max_lat=5, rand on, 200 flushes → every measured L lies in 2..5 and both 2 and 5 occur; cfg_max_lat=1, cfg_min_lat=4 → every L=4.
- Granted ch1 drops req 2 cycles into a latency-6 wait → proto_err[1] pulses once, no ack, flush_cnt unchanged, block back in IDLE 2 cycles later.
- reset_n pulsed low during ACK → flush_ack, busy and flush_cnt read 0 immediately; first grant after reset goes to ch0.
- flush_cnt forced to 16'hFFFE, then 3 flushes → flush_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/fencei_mc_flush_resp.sv
// Multi-channel FENCE.I flush responder.
// One shared flush engine serves NUM_CH level-sensitive flush_req/flush_ack
// requesters. Grants are round-robin; each flush is acknowledged after a
// fixed or LFSR-derived latency. A request that drops while it is being
// served raises a proto_err pulse. Completed flushes are counted (saturating).
module fencei_mc_flush_resp #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned LAT_W  = 8,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] flush_req,
    output logic [NUM_CH-1:0] flush_ack,
    input  logic [LAT_W-1:0]  cfg_min_lat,
    input  logic [LAT_W-1:0]  cfg_max_lat,
    input  logic              cfg_rand_en,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch,
    output logic [NUM_CH-1:0] proto_err,
    output logic [15:0]       flush_cnt
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWait    = 2'd1;
    localparam logic [1:0] StAck     = 2'd2;
    localparam logic [1:0] StRecover = 2'd3;

    localparam logic [CH_W-1:0] PtrReset = CH_W'(NUM_CH - 1);

    logic [1:0]        state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] perr_q, perr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic [LAT_W-1:0]  lfsr_lat;
    logic [LAT_W:0]    lat_sum;
    logic [LAT_W-1:0]  lat;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    int unsigned       arb_idx;

    // LFSR bits feeding the latency; zero-extended when the counter is wider.
    if (LAT_W <= 16) begin : g_lat_narrow
        assign lfsr_lat = lfsr_q[LAT_W-1:0];
    end else begin : g_lat_wide
        assign lfsr_lat = {{(LAT_W - 16){1'b0}}, lfsr_q};
    end

    // Fibonacci LFSR, taps 16,14,13,11; free-running every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Latency selection; the sum is one bit wider so it cannot wrap.
    always_comb begin
        lat_sum = {1'b0, cfg_min_lat} + {1'b0, lfsr_lat};
        if (!cfg_rand_en || (cfg_max_lat < cfg_min_lat)) begin
            lat = cfg_min_lat;
        end else if (lat_sum > {1'b0, cfg_max_lat}) begin
            lat = cfg_max_lat;
        end else begin
            lat = lat_sum[LAT_W-1:0];
        end
    end

    // Round-robin search from ptr+1; the loop runs backwards so the nearest
    // requester after the pointer is the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        arb_idx   = 0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            arb_idx = (int'(ptr_q) + 1 + i) % NUM_CH;
            if (flush_req[arb_idx]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(arb_idx);
            end
        end
    end

    // Next-state logic of the flush engine and its registered outputs.
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        ptr_d     = ptr_q;
        ch_d      = ch_q;
        ack_d     = '0;
        perr_d    = '0;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    ch_d      = grant_ch;
                    ptr_d     = grant_ch;
                    lat_cnt_d = lat;
                    if (lat == '0) begin
                        state_d         = StAck;
                        ack_d[grant_ch] = 1'b1;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                // A dropped request aborts the flush; it must never be acked.
                if (!flush_req[ch_q]) begin
                    perr_d[ch_q] = 1'b1;
                    state_d      = StRecover;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(1)) begin
                        state_d     = StAck;
                        ack_d[ch_q] = 1'b1;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            StAck: begin
                state_d = StRecover;
            end
            StRecover: begin
                // Requests ignored so the acked requester can deassert.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            lat_cnt_q <= '0;
            ptr_q     <= PtrReset;
            ch_q      <= '0;
            ack_q     <= '0;
            perr_q    <= '0;
            cnt_q     <= 16'h0000;
            lfsr_q    <= 16'hACE1;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            ptr_q     <= ptr_d;
            ch_q      <= ch_d;
            ack_q     <= ack_d;
            perr_q    <= perr_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign flush_ack = ack_q;
    assign proto_err = perr_q;
    assign flush_cnt = cnt_q;
    assign active_ch = ch_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fencei_mc_flush_resp.sv
// Scoreboard bench for fencei_mc_flush_resp (4 channels, 4-bit latency).
// Stimulus pushes expected acks / protocol errors; a negedge monitor pops and
// compares whenever the DUT pulses flush_ack or proto_err.
module tb_fencei_mc_flush_resp;

    localparam int NCH = 4;
    localparam int LW  = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [NCH-1:0] flush_req = '0;
    logic [NCH-1:0] flush_ack;
    logic [LW-1:0]  cfg_min_lat = '0;
    logic [LW-1:0]  cfg_max_lat = '0;
    logic           cfg_rand_en = 1'b0;
    logic           busy;
    logic [1:0]     active_ch;
    logic [NCH-1:0] proto_err;
    logic [15:0]    flush_cnt;

    fencei_mc_flush_resp #(
        .NUM_CH (NCH),
        .LAT_W  (LW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_req   (flush_req),
        .flush_ack   (flush_ack),
        .cfg_min_lat (cfg_min_lat),
        .cfg_max_lat (cfg_max_lat),
        .cfg_rand_en (cfg_rand_en),
        .busy        (busy),
        .active_ch   (active_ch),
        .proto_err   (proto_err),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int cyc;
        int grant;
        int lo;
        int hi;
    } ack_exp_t;

    typedef struct {
        int ch;
        int cyc;
    } perr_exp_t;

    ack_exp_t  ack_q[$];
    perr_exp_t perr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit seen_lo = 1'b0;
    bit seen_hi = 1'b0;
    logic [15:0] m_lfsr;

    // Posedge counter used to timestamp grants and acks.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input int mn, input int mx, input bit rnd,
                                   input logic [15:0] lf);
        int s;
        if (!rnd || mx < mn) return mn;
        s = mn + int'(lf[LW-1:0]);
        return (s > mx) ? mx : s;
    endfunction

    // Monitor: pops one expectation per output pulse.
    always @(negedge clk) begin
        if (reset_n) begin
            if (flush_ack != '0) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", flush_ack, 0);
                end else begin
                    ack_exp_t it;
                    int meas;
                    it = ack_q.pop_front();
                    check("ack_channel", flush_ack, 1 << it.ch);
                    check("ack_cycle", cyc, it.cyc);
                    meas = cyc - it.grant;
                    check("ack_latency_in_range", (meas >= it.lo && meas <= it.hi), 1);
                    if (meas == it.lo) seen_lo = 1'b1;
                    if (meas == it.hi) seen_hi = 1'b1;
                end
            end
            if (proto_err != '0) begin
                if (perr_q.size() == 0) begin
                    check("unexpected_proto_err", proto_err, 0);
                end else begin
                    perr_exp_t pe;
                    pe = perr_q.pop_front();
                    check("proto_err_channel", proto_err, 1 << pe.ch);
                    check("proto_err_cycle", cyc, pe.cyc);
                end
            end
        end
    end

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_ack(input int ch, input int at, input int grant, input int lo,
                            input int hi);
        ack_exp_t it;
        it.ch = ch; it.cyc = at; it.grant = grant; it.lo = lo; it.hi = hi;
        ack_q.push_back(it);
    endtask

    // Held request on ch0: consecutive grants 3 cycles after each ack.
    task automatic run_held(input int n, input int lo, input int hi, output int last);
        int g, l;
        flush_req[0] = 1'b1;
        g = cyc + 1;
        last = g;
        for (int k = 0; k < n; k++) begin
            wait_until(g - 1);
            l = exp_lat(int'(cfg_min_lat), int'(cfg_max_lat), cfg_rand_en, m_lfsr);
            push_ack(0, g + l, g, lo, hi);
            last = g + l;
            g = g + l + 3;
        end
        wait_until(last);
        flush_req[0] = 1'b0;
        wait_until(last + 2);
    endtask

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, busy_n, last;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_flush_ack", flush_ack, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_busy", busy, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fixed latency 3 on ch0.
        cfg_min_lat = 4'd3;
        flush_req[0] = 1'b1;
        g = cyc + 1;
        push_ack(0, g + 3, g, 3, 3);
        busy_n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (cyc == g) check("lat3_active_ch", active_ch, 0);
            if (cyc == g + 3) flush_req[0] = 1'b0;
        end
        check("lat3_busy_cycles", busy_n, 5);
        check("lat3_flush_cnt", flush_cnt, 1);

        // Fresh reset, all four channels at once with zero latency.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cfg_min_lat = 4'd0;
        flush_req = 4'hF;
        g = cyc + 1;
        for (int i = 0; i < NCH; i++) push_ack(i, g + 3 * i, g + 3 * i, 0, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) if (cyc == g + 3 * i) flush_req[i] = 1'b0;
        end
        check("rr_flush_cnt", flush_cnt, 4);
        check("rr_busy_idle", busy, 0);

        // Random latency in 2..5, then inverted bounds (always min).
        cfg_min_lat = 4'd2;
        cfg_max_lat = 4'd5;
        cfg_rand_en = 1'b1;
        seen_lo = 1'b0;
        seen_hi = 1'b0;
        run_held(200, 2, 5, last);
        check("rand_saw_min", seen_lo, 1);
        check("rand_saw_max", seen_hi, 1);
        cfg_min_lat = 4'd4;
        cfg_max_lat = 4'd1;
        run_held(10, 4, 4, last);
        check("rand_flush_cnt", flush_cnt, 214);

        // ch1 drops its request during a latency-6 wait.
        cfg_rand_en = 1'b0;
        cfg_min_lat = 4'd6;
        flush_req[1] = 1'b1;
        g = cyc + 1;
        begin
            perr_exp_t pe;
            pe.ch = 1; pe.cyc = g + 2;
            perr_q.push_back(pe);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cyc == g + 1) flush_req[1] = 1'b0;
            if (cyc == g + 2) begin
                check("abort_busy_recover", busy, 1);
                check("abort_active_ch", active_ch, 1);
            end
            if (cyc == g + 3) check("abort_back_idle", busy, 0);
        end
        check("abort_flush_cnt", flush_cnt, 214);

        // Reset asserted while ch2 is in ACK.
        cfg_min_lat = 4'd2;
        flush_req[2] = 1'b1;
        g = cyc + 1;
        push_ack(2, g + 2, g, 2, 2);
        wait_until(g + 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_flush_ack", flush_ack, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_flush_cnt", flush_cnt, 0);
        flush_req = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cfg_min_lat = 4'd0;
        flush_req = 4'b1001;
        g = cyc + 1;
        push_ack(0, g, g, 0, 0);
        push_ack(3, g + 3, g + 3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cyc == g) begin
                check("post_rst_grant_ch0", active_ch, 0);
                flush_req[0] = 1'b0;
            end
            if (cyc == g + 3) flush_req[3] = 1'b0;
        end
        wait_until(g + 5);

        // Counter saturation.
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        check("sat_preload", flush_cnt, 16'hFFFE);
        flush_req[1] = 1'b1;
        g = cyc + 1;
        for (int i = 0; i < 3; i++) push_ack(1, g + 3 * i, g + 3 * i, 0, 0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (cyc == g + 3) check("sat_after_2", flush_cnt, 16'hFFFF);
            if (cyc == g + 6) flush_req[1] = 1'b0;
        end
        check("sat_final", flush_cnt, 16'hFFFF);

        repeat (3) @(negedge clk);
        check("ack_queue_drained", ack_q.size(), 0);
        check("perr_queue_drained", perr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
